// File: rtl/dma_pkg.sv
// Shared DMA definitions: FSM state encoding and the system word width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dma_pkg;

    // Word width shared by the memory, the CPU and the DMA engine.
    localparam int WORD_SIZE = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/dma_addr_counter.sv
// Holds the latched base/length and the word count; produces base+count and the last-word flag.
// Latency: load and step take effect at the next rising edge; addr and last are combinational.
// Backpressure: count only advances when step is high, so stalls simply hold the address.
module dma_addr_counter #(
    parameter int WORD_SIZE = dma_pkg::WORD_SIZE,
    parameter int LEN_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [WORD_SIZE-1:0] load_base,
    input  logic [LEN_W-1:0]     load_len,
    input  logic                 step,
    output logic [WORD_SIZE-1:0] addr,
    output logic                 last
);

    logic [WORD_SIZE-1:0] base;
    logic [LEN_W-1:0]     len;
    logic [LEN_W-1:0]     count;

    // Latch a new command, otherwise advance one word per accepted handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            base  <= '0;
            len   <= '0;
            count <= '0;
        end else if (load) begin
            base  <= load_base;
            len   <= load_len;
            count <= '0;
        end else if (step) begin
            count <= count + LEN_W'(1);
        end
    end

    // Address wraps modulo 2^WORD_SIZE; decoding is left to the memory.
    assign addr = base + WORD_SIZE'(count);
    assign last = (count == len - LEN_W'(1));

endmodule

// File: rtl/dma_write_engine.sv
// Single-channel DMA: moves cmd_len device words into memory port 2 at base address cmd_addr.
// Latency: br one cycle after cmd; first write the cycle after grant; dma_end one cycle after last write.
// Backpressure: dev_ready follows bg in XFER; a dropped grant pauses the transfer without losing state.
module dma_write_engine #(
    parameter int WORD_SIZE = dma_pkg::WORD_SIZE,
    parameter int LEN_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd,
    input  logic [WORD_SIZE-1:0] cmd_addr,
    input  logic [LEN_W-1:0]     cmd_len,
    output logic                 br,
    input  logic                 bg,
    input  logic [WORD_SIZE-1:0] dev_data,
    input  logic                 dev_valid,
    output logic                 dev_ready,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_wdata,
    output logic                 busy,
    output logic                 dma_end
);

    import dma_pkg::*;

    state_t               state;
    logic                 hs;
    logic                 last;
    logic                 load;
    logic [WORD_SIZE-1:0] addr;

    // Only accept commands in IDLE; a zero-length command never touches the counter.
    assign load = (state == IDLE) && cmd && (cmd_len != '0);

    // Reset gates the strobe so a handshake coinciding with reset is never committed.
    assign dev_ready = (state == XFER) && bg && !reset;
    assign hs        = dev_ready && dev_valid;
    assign mem_write = hs;
    assign mem_addr  = hs ? addr : '0;
    assign mem_wdata = hs ? dev_data : '0;

    dma_addr_counter #(
        .WORD_SIZE (WORD_SIZE),
        .LEN_W     (LEN_W)
    ) u_addr_counter (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_base (cmd_addr),
        .load_len  (cmd_len),
        .step      (hs),
        .addr      (addr),
        .last      (last)
    );

    // Control FSM; br, busy and dma_end are registered alongside the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            br      <= 1'b0;
            busy    <= 1'b0;
            dma_end <= 1'b0;
        end else begin
            dma_end <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd) begin
                        busy <= 1'b1;
                        if (cmd_len != '0) begin
                            state <= REQ;
                            br    <= 1'b1;
                        end else begin
                            state   <= DONE;
                            dma_end <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (bg) begin
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (hs && last) begin
                        state   <= DONE;
                        br      <= 1'b0;
                        dma_end <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    br    <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    br    <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_write_engine.sv
// Directed bench for dma_write_engine: transfers, grant pause, device stalls, zero length, wrap, reset.
// Latency: inputs change on the falling edge, outputs are checked 1 ns later.
// Backpressure: bg and dev_valid are driven directly by the directed steps.
module tb_dma_write_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd;
    logic [15:0] cmd_addr;
    logic [15:0] cmd_len;
    logic        br;
    logic        bg;
    logic [15:0] dev_data;
    logic        dev_valid;
    logic        dev_ready;
    logic [15:0] mem_addr;
    logic        mem_write;
    logic [15:0] mem_wdata;
    logic        busy;
    logic        dma_end;

    int tests = 0;
    int fails = 0;
    int wr_cnt = 0;
    int end_cnt = 0;
    int w0;
    int e0;

    dma_write_engine #(
        .WORD_SIZE (16),
        .LEN_W     (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd       (cmd),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .br        (br),
        .bg        (bg),
        .dev_data  (dev_data),
        .dev_valid (dev_valid),
        .dev_ready (dev_ready),
        .mem_addr  (mem_addr),
        .mem_write (mem_write),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .dma_end   (dma_end)
    );

    always #5 clk = ~clk;

    // Count write strobes and completion pulses, sampled mid low phase.
    always begin
        @(negedge clk);
        #3;
        if (mem_write) wr_cnt = wr_cnt + 1;
        if (dma_end) end_cnt = end_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests = tests + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue a command and walk through REQ with the grant given; returns at the first XFER cycle.
    task automatic start(input logic [15:0] addr, input logic [15:0] len);
        cmd = 1'b1; cmd_addr = addr; cmd_len = len; dev_valid = 1'b0;
        #1;
        chk("idle_br", {31'd0, br}, 32'd0);
        @(negedge clk);
        cmd = 1'b0; bg = 1'b1; dev_valid = 1'b0;
        #1;
        chk("req_br", {31'd0, br}, 32'd1);
        chk("req_busy", {31'd0, busy}, 32'd1);
        chk("req_ready", {31'd0, dev_ready}, 32'd0);
        @(negedge clk);
    endtask

    // One accepted word: strobe, address and data must all appear this cycle.
    task automatic word(input logic [15:0] exp_addr, input logic [15:0] data);
        dev_valid = 1'b1; dev_data = data;
        #1;
        chk("wr_strobe", {31'd0, mem_write}, 32'd1);
        chk("wr_addr", {16'd0, mem_addr}, {16'd0, exp_addr});
        chk("wr_data", {16'd0, mem_wdata}, {16'd0, data});
        @(negedge clk);
    endtask

    // A cycle with no handshake expected; br must stay up.
    task automatic idle_cycle(input logic g, input logic v);
        bg = g; dev_valid = v; dev_data = 16'hDEAD;
        #1;
        chk("stall_write", {31'd0, mem_write}, 32'd0);
        chk("stall_br", {31'd0, br}, 32'd1);
        @(negedge clk);
    endtask

    // DONE cycle followed by the return to IDLE.
    task automatic done_chk();
        dev_valid = 1'b0;
        #1;
        chk("done_end", {31'd0, dma_end}, 32'd1);
        chk("done_br", {31'd0, br}, 32'd0);
        chk("done_busy", {31'd0, busy}, 32'd1);
        chk("done_write", {31'd0, mem_write}, 32'd0);
        @(negedge clk);
        #1;
        chk("idle_end", {31'd0, dma_end}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; cmd = 1'b0; cmd_addr = '0; cmd_len = '0;
        bg = 1'b0; dev_data = '0; dev_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_br", {31'd0, br}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_end", {31'd0, dma_end}, 32'd0);
        chk("rst_write", {31'd0, mem_write}, 32'd0);
        chk("rst_ready", {31'd0, dev_ready}, 32'd0);
        chk("rst_addr", {16'd0, mem_addr}, 32'd0);
        chk("rst_wdata", {16'd0, mem_wdata}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Basic 12-word transfer at 0x00C8 with data 1..12.
        w0 = wr_cnt;
        start(16'h00C8, 16'd12);
        for (int i = 0; i < 12; i++) word(16'h00C8 + 16'(i), 16'(i + 1));
        done_chk();
        chk("t1_writes", 32'(wr_cnt - w0), 32'd12);

        // Grant dropped for 3 cycles after the 5th word.
        w0 = wr_cnt;
        start(16'h00C8, 16'd12);
        for (int i = 0; i < 5; i++) word(16'h00C8 + 16'(i), 16'(i + 1));
        for (int i = 0; i < 3; i++) idle_cycle(1'b0, 1'b1);
        bg = 1'b1;
        for (int i = 5; i < 12; i++) word(16'h00C8 + 16'(i), 16'(i + 1));
        done_chk();
        chk("t2_writes", 32'(wr_cnt - w0), 32'd12);

        // Device valid every other cycle.
        w0 = wr_cnt;
        start(16'h00C8, 16'd12);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) idle_cycle(1'b1, 1'b0);
            word(16'h00C8 + 16'(i), 16'(16'h0100 + i));
        end
        done_chk();
        chk("t3_writes", 32'(wr_cnt - w0), 32'd12);

        // Zero length: no request, completion the cycle after cmd.
        cmd = 1'b1; cmd_addr = 16'h1234; cmd_len = 16'd0; bg = 1'b0;
        #1;
        chk("z_br0", {31'd0, br}, 32'd0);
        @(negedge clk);
        cmd = 1'b0;
        #1;
        chk("z_end", {31'd0, dma_end}, 32'd1);
        chk("z_br1", {31'd0, br}, 32'd0);
        @(negedge clk);
        #1;
        chk("z_idle_end", {31'd0, dma_end}, 32'd0);
        chk("z_idle_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);

        // Second command mid-transfer is ignored.
        w0 = wr_cnt;
        start(16'h0100, 16'd3);
        word(16'h0100, 16'hA0);
        cmd = 1'b1; cmd_addr = 16'h0500; cmd_len = 16'd9;
        word(16'h0101, 16'hA1);
        cmd = 1'b0;
        word(16'h0102, 16'hA2);
        done_chk();
        chk("t4_writes", 32'(wr_cnt - w0), 32'd3);

        // Address wrap past 0xFFFF.
        start(16'hFFFE, 16'd4);
        word(16'hFFFE, 16'h0011);
        word(16'hFFFF, 16'h0022);
        word(16'h0000, 16'h0033);
        word(16'h0001, 16'h0044);
        done_chk();

        // Reset after 6 words: everything drops, no completion pulse.
        e0 = end_cnt;
        start(16'h00C8, 16'd12);
        for (int i = 0; i < 6; i++) word(16'h00C8 + 16'(i), 16'(i + 1));
        reset = 1'b1; dev_valid = 1'b1; bg = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("r_br", {31'd0, br}, 32'd0);
        chk("r_busy", {31'd0, busy}, 32'd0);
        chk("r_write", {31'd0, mem_write}, 32'd0);
        chk("r_ready", {31'd0, dev_ready}, 32'd0);
        chk("r_addr", {16'd0, mem_addr}, 32'd0);
        chk("r_end", {31'd0, dma_end}, 32'd0);
        @(negedge clk);
        dev_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("r_no_end", 32'(end_cnt - e0), 32'd0);
        start(16'h0200, 16'd2);
        word(16'h0200, 16'h0055);
        word(16'h0201, 16'h0066);
        done_chk();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
